// File: rtl/uart_rx_frame_pkg.sv
// uart_rx_frame_pkg: sync byte, frame FSM states and timeout sizing for the UART frame controller
package uart_rx_frame_pkg;
    localparam logic [7:0] SYNC = 8'hA5;
    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, DRAIN} state_t;
    function automatic longint unsigned tmo_cycles(input longint unsigned clk_freq,
                                                   input longint unsigned baud_rate,
                                                   input longint unsigned timeout_bytes);
        return timeout_bytes * 10 * clk_freq / baud_rate;
    endfunction
endpackage

// File: rtl/uart_rx_byte_sync.sv
// uart_rx_byte_sync: synchronises the byte-ready level and captures one byte per rising edge
module uart_rx_byte_sync
    import uart_rx_frame_pkg::*;
(
    input  logic       clk,
    input  logic       RX_rst,
    input  logic       RX_rdy,
    input  logic [7:0] RX_out,
    output logic       byte_stb,
    output logic [7:0] byte_val
);
    logic [2:0] rdy_q;
    logic       rise;
    assign rise = rdy_q[1] & ~rdy_q[2];
    always_ff @(posedge clk or negedge RX_rst) begin
        if (!RX_rst) begin
            rdy_q    <= '0;
            byte_stb <= 1'b0;
            byte_val <= '0;
        end else begin
            rdy_q    <= {rdy_q[1:0], RX_rdy};
            byte_stb <= rise;
            byte_val <= rise ? RX_out : byte_val;
        end
    end
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses SYNC/LEN/payload/XOR frames from the byte receiver into a valid/ready packet stream
module uart_rx_frame_ctrl
    import uart_rx_frame_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int MAX_LEN       = 16,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       RX_rst,
    input  logic       RX_rdy,
    input  logic       RX_idle,
    input  logic [7:0] RX_out,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic [7:0] pkt_len,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_tmo,
    output logic       err_ovr,
    output logic       busy
);
    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    localparam int TMO = int'(tmo_cycles(64'(CLK_FREQ), 64'(BAUD_RATE), 64'(TIMEOUT_BYTES)));
    localparam int CW = $clog2(TMO + 1);
    localparam logic [7:0] MAXL = 8'(MAX_LEN);

    state_t        state, nxt;
    logic          stb, tmo_on, expire, len_ok, chk_ok, pay_done, unused_idle;
    logic [7:0]    bval, len, chk;
    logic [IW-1:0] idx, rd;
    logic [CW-1:0] tmo_cnt;
    logic [1:0]    idle_q;
    logic [7:0]    mem [MAX_LEN];

    uart_rx_byte_sync u_sync (
        .clk      (clk),
        .RX_rst   (RX_rst),
        .RX_rdy   (RX_rdy),
        .RX_out   (RX_out),
        .byte_stb (stb),
        .byte_val (bval)
    );

    assign tmo_on      = state inside {LEN, PAYLOAD, CHECK};
    assign expire      = tmo_on && !stb && tmo_cnt == CW'(TMO - 1);
    assign len_ok      = bval != 8'd0 && bval <= MAXL;
    assign chk_ok      = bval == chk;
    assign pay_done    = 8'(idx) + 8'd1 == len;
    assign unused_idle = idle_q[1];
    assign busy        = state != HUNT;
    assign pkt_valid   = state == DRAIN;
    assign pkt_data    = pkt_valid ? mem[rd[AW-1:0]] : 8'd0;
    assign pkt_last    = pkt_valid && 8'(rd) == pkt_len - 8'd1;

    always_ff @(posedge clk or negedge RX_rst) begin
        if (!RX_rst) state <= HUNT;
        else         state <= nxt;
    end

    always_comb begin
        nxt     = state;
        err_len = 1'b0;
        err_chk = 1'b0;
        err_ovr = 1'b0;
        err_tmo = expire;
        unique case (state)
            HUNT:    nxt = stb && bval == SYNC ? LEN : HUNT;
            LEN:     if (stb) begin
                         nxt     = len_ok ? PAYLOAD : HUNT;
                         err_len = !len_ok;
                     end
            PAYLOAD: if (stb && pay_done) nxt = CHECK;
            CHECK:   if (stb) begin
                         nxt     = chk_ok ? DRAIN : HUNT;
                         err_chk = !chk_ok;
                     end
            DRAIN:   begin
                         nxt     = pkt_ready && pkt_last ? HUNT : DRAIN;
                         err_ovr = stb;
                     end
            default: nxt = HUNT;
        endcase
        if (expire) nxt = HUNT;
    end

    always_ff @(posedge clk or negedge RX_rst) begin
        if (!RX_rst) begin
            len     <= '0;
            chk     <= '0;
            idx     <= '0;
            rd      <= '0;
            pkt_len <= '0;
            tmo_cnt <= '0;
            idle_q  <= '0;
        end else begin
            idle_q  <= {idle_q[0], RX_idle};
            tmo_cnt <= stb || !tmo_on ? '0 : tmo_cnt + 1'b1;
            if (stb && state == LEN) begin
                len <= bval;
                chk <= bval;
                idx <= '0;
            end
            if (stb && state == PAYLOAD) begin
                chk <= chk ^ bval;
                idx <= idx + 1'b1;
            end
            if (stb && state == CHECK && chk_ok) begin
                pkt_len <= len;
                rd      <= '0;
            end
            if (pkt_valid && pkt_ready) rd <= rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (stb && state == PAYLOAD) mem[idx[AW-1:0]] <= bval;
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and randomized frames checked against per-frame expected outcomes
module tb_uart_rx_frame_ctrl;
    localparam int CLK_FREQ      = 960_000;
    localparam int BAUD_RATE     = 9600;
    localparam int MAX_LEN       = 16;
    localparam int TIMEOUT_BYTES = 4;
    localparam int TMO = TIMEOUT_BYTES * 10 * CLK_FREQ / BAUD_RATE;

    logic       clk = 1'b0, RX_rst = 1'b0, RX_rdy = 1'b0, RX_idle = 1'b1, pkt_ready = 1'b0;
    logic [7:0] RX_out = 8'd0;
    logic [7:0] pkt_data, pkt_len;
    logic       pkt_valid, pkt_last, err_chk, err_len, err_tmo, err_ovr, busy;

    int n_pass = 0, n_total = 0, cyc = 0, ready_mode = 0;
    int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0;
    logic [7:0] got_d[$], got_n[$], pay[$];
    bit         got_l[$];
    int         got_t[$];
    logic       prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [7:0] prev_d = 8'd0;

    uart_rx_frame_ctrl #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .MAX_LEN(MAX_LEN), .TIMEOUT_BYTES(TIMEOUT_BYTES)
    ) dut (
        .clk(clk), .RX_rst(RX_rst), .RX_rdy(RX_rdy), .RX_idle(RX_idle), .RX_out(RX_out),
        .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_last(pkt_last),
        .pkt_len(pkt_len), .err_chk(err_chk), .err_len(err_len), .err_tmo(err_tmo),
        .err_ovr(err_ovr), .busy(busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        pkt_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (RX_rst) begin
            if (prev_v && !prev_r) begin
                check("hold_valid", pkt_valid, 1);
                check("hold_data", pkt_data, prev_d);
                check("hold_last", pkt_last, prev_l);
            end
            if (pkt_valid && pkt_ready) begin
                got_d.push_back(pkt_data);
                got_l.push_back(pkt_last);
                got_n.push_back(pkt_len);
                got_t.push_back(cyc);
            end
            n_chk += int'(err_chk);
            n_len += int'(err_len);
            n_tmo += int'(err_tmo);
            n_ovr += int'(err_ovr);
        end
        prev_v = pkt_valid;
        prev_r = pkt_ready;
        prev_d = pkt_data;
        prev_l = pkt_last;
    end

    task automatic send_byte(input logic [7:0] b);
        RX_out = b;
        RX_rdy = 1'b1;
        repeat (8) @(posedge clk);
        RX_rdy = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("idle", busy, 0);
    endtask

    task automatic clear_got();
        got_d.delete();
        got_l.delete();
        got_n.delete();
        got_t.delete();
    endtask

    // send SYNC, len, n_sent bytes of pay and optionally the checksum; expect the given error counts
    task automatic run(input logic [7:0] len, input int n_sent, input bit send_chk, input bit corrupt,
                       input int n_junk, input int el, input int ec, input int et);
        int b_chk = n_chk, b_len = n_len, b_tmo = n_tmo, b_ovr = n_ovr;
        logic [7:0] c = len, j;
        bit good = send_chk && !corrupt;
        clear_got();
        for (int i = 0; i < n_junk; i++) begin
            j = 8'($urandom);
            send_byte(j == 8'hA5 ? 8'h5A : j);
        end
        send_byte(8'hA5);
        send_byte(len);
        for (int i = 0; i < n_sent; i++) begin
            send_byte(pay[i]);
            c ^= pay[i];
        end
        if (send_chk) send_byte(corrupt ? c ^ 8'h80 : c);
        if (et != 0) begin
            check("busy_partial", busy, 1);
            repeat (TMO + 50) @(posedge clk);
        end
        wait_idle();
        repeat (4) @(posedge clk);
        check("pkt_count", got_d.size(), good ? int'(len) : 0);
        if (good) for (int i = 0; i < got_d.size() && i < int'(len); i++) begin
            check("pkt_data", got_d[i], pay[i]);
            check("pkt_last", got_l[i], i == int'(len) - 1);
            check("pkt_len", got_n[i], len);
            if (ready_mode == 0 && i > 0) check("back_to_back", got_t[i] - got_t[i-1], 1);
        end
        check("err_len", n_len - b_len, el);
        check("err_chk", n_chk - b_chk, ec);
        check("err_tmo", n_tmo - b_tmo, et);
        check("err_ovr", n_ovr - b_ovr, 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        int kind, nj, b_ovr, b_tmo;
        logic [7:0] len;
        repeat (3) @(negedge clk);
        check("reset_outs", {pkt_data, pkt_valid, pkt_last, pkt_len, err_chk, err_len, err_tmo, err_ovr, busy}, 0);
        RX_rst = 1'b1;
        repeat (3) @(posedge clk);

        ready_mode = 0;
        pay = '{8'h11, 8'h22, 8'h33};
        run(8'd3, 3, 1, 0, 0, 0, 0, 0);
        pay = '{8'h10, 8'h20};
        run(8'd2, 2, 1, 1, 0, 0, 1, 0);
        pay = '{8'h7E};
        run(8'd1, 1, 1, 0, 0, 0, 0, 0);
        run(8'd0, 0, 0, 0, 0, 1, 0, 0);
        run(8'd17, 0, 0, 0, 0, 1, 0, 0);
        pay = '{8'h01, 8'h02};
        run(8'd4, 2, 0, 0, 0, 0, 0, 1);
        pay = '{8'h55};
        run(8'd1, 1, 1, 0, 0, 0, 0, 0);

        ready_mode = 2;
        b_ovr = n_ovr;
        b_tmo = n_tmo;
        clear_got();
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'h02 ^ 8'hAA ^ 8'hBB);
        repeat (2000) @(posedge clk);
        #1;
        check("bp_valid", pkt_valid, 1);
        check("bp_data", pkt_data, 8'hAA);
        check("bp_last", pkt_last, 0);
        check("bp_len", pkt_len, 8'd2);
        send_byte(8'hA5);
        #1;
        check("ovr_pulse", n_ovr - b_ovr, 1);
        check("ovr_data", pkt_data, 8'hAA);
        ready_mode = 0;
        wait_idle();
        repeat (4) @(posedge clk);
        check("bp_seq", got_d.size() == 2 ? {got_d[0], got_d[1], 7'b0, got_l[0], 7'b0, got_l[1]} : 32'h0, 32'hAABB0001);
        check("tmo_in_drain", n_tmo - b_tmo, 0);
        check("no_resync", busy, 0);

        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        #1;
        check("pre_rst_busy", busy, 1);
        @(negedge clk);
        RX_rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", pkt_valid, 0);
        repeat (3) @(negedge clk);
        RX_rst = 1'b1;
        pay = '{8'h22};
        run(8'd1, 1, 1, 0, 0, 0, 0, 0);

        ready_mode = 1;
        for (int k = 0; k < 40; k++) begin
            kind = int'($urandom_range(0, 3));
            len = 8'($urandom_range(1, MAX_LEN));
            nj = int'($urandom_range(0, 2));
            pay.delete();
            for (int i = 0; i < MAX_LEN; i++) pay.push_back(8'($urandom));
            case (kind)
                0: run(len, int'(len), 1, 0, nj, 0, 0, 0);
                1: run(len, int'(len), 1, 1, nj, 0, 1, 0);
                2: begin
                    len = $urandom_range(0, 1) != 0 ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
                    run(len, 0, 0, 0, nj, 1, 0, 0);
                end
                default: run(len, int'($urandom_range(0, int'(len))), 0, 0, nj, 0, 0, 1);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
